// File: rtl/rsa_xcel_mont_modexp_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rsa_xcel_mont_ModExpCtrlPkg (package)
//  Purpose  : Shared types and constants for the Montgomery modular
//             exponentiation controller: controller state encoding and the
//             datapath mux-select values.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package rsa_xcel_mont_ModExpCtrlPkg;

    // Controller states, explicitly encoded on 3 bits.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } ctrl_state_t;

    // Datapath register input selects: load from the request stream, or
    // update from the datapath itself (e >> 1, MulRem products).
    localparam logic SEL_LOAD = 1'b0;
    localparam logic SEL_UPD  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/rsa_xcel_mont_modexp_ctrl_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : rsa_xcel_mont_MulRemTracker
//  Purpose  : Per-unit handshake tracker for one MulRem unit. Issues one
//             request per loop iteration when the unit is needed, then
//             accepts exactly one product for that request.
//  Ports    : clk, reset    - clock, synchronous active-high reset
//             need          - this unit takes part in the current iteration
//             start         - controller is in the issue phase
//             wait_en       - controller is in the wait phase
//             clear         - iteration finished; forget issued/captured
//             i_rdy, o_val  - request-ready / product-valid from the unit
//             i_val, o_rdy  - request-valid / product-ready to the unit
//             capture       - product accepted this cycle (load the register)
//             issue_ok      - nothing left to issue (incl. a fire this cycle)
//             done          - nothing left to capture (incl. a capture now)
//  Revision : 1.0 - initial release
// ============================================================================
module rsa_xcel_mont_MulRemTracker (
    input  logic clk,
    input  logic reset,
    input  logic need,
    input  logic start,
    input  logic wait_en,
    input  logic clear,
    input  logic i_rdy,
    input  logic o_val,
    output logic i_val,
    output logic o_rdy,
    output logic capture,
    output logic issue_ok,
    output logic done
);

    logic r_issued;
    logic r_captured;
    logic w_fire;

    always_comb begin
        i_val    = start & need & ~r_issued;
        w_fire   = i_val & i_rdy;
        issue_ok = ~need | r_issued | w_fire;
        // Only a unit we actually issued to is offered o_rdy, so a stray
        // o_val from an idle unit is never consumed.
        o_rdy    = wait_en & r_issued & ~r_captured;
        capture  = o_rdy & o_val;
        done     = ~r_issued | r_captured | capture;
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_issued   <= 1'b0;
            r_captured <= 1'b0;
        end else begin
            if (w_fire) begin
                r_issued <= 1'b1;
            end
            if (capture) begin
                r_captured <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rsa_xcel_mont_modexp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : rsa_xcel_mont_modexp_ctrl
//  Purpose  : Control unit for the Montgomery modular-exponentiation datapath.
//             Right-to-left square-and-multiply: load b/e/n/r, then per
//             exponent bit r = r*b (if bit set), b = b*b (unless last bit),
//             e >>= 1. The r and b MulRem units run concurrently with
//             independent val/rdy handshakes.
//  Ports    : clk, reset                 - clock, sync active-high reset
//             istream_val/rdy            - operand load handshake
//             ostream_val/rdy            - result handshake
//             e/r/b_mux_sel              - 0 = load input, 1 = update
//             e/r/b/n_reg_en             - datapath register enables
//             r/b_mulrem_i_val/i_rdy     - MulRem request handshakes
//             r/b_mulrem_o_val/o_rdy     - MulRem product handshakes
//             e_reg_out                  - current exponent
//  Revision : 1.0 - initial release
// ============================================================================
module rsa_xcel_mont_modexp_ctrl
    import rsa_xcel_mont_ModExpCtrlPkg::*;
#(
    parameter int p_nbits = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               istream_val,
    output logic               istream_rdy,
    output logic               ostream_val,
    input  logic               ostream_rdy,
    output logic               e_mux_sel,
    output logic               r_mux_sel,
    output logic               b_mux_sel,
    output logic               e_reg_en,
    output logic               r_reg_en,
    output logic               b_reg_en,
    output logic               n_reg_en,
    output logic               r_mulrem_i_val,
    output logic               r_mulrem_o_rdy,
    output logic               b_mulrem_i_val,
    output logic               b_mulrem_o_rdy,
    input  logic [p_nbits-1:0] e_reg_out,
    input  logic               r_mulrem_i_rdy,
    input  logic               r_mulrem_o_val,
    input  logic               b_mulrem_i_rdy,
    input  logic               b_mulrem_o_val
);

    ctrl_state_t r_state;
    logic        r_need_rmul;
    logic        r_need_bmul;

    logic w_in_issue;
    logic w_in_wait;
    logic w_all_issued;
    logic w_all_done;
    logic w_clear;

    logic w_rmul_i_val, w_rmul_o_rdy, w_rmul_capture, w_rmul_issue_ok, w_rmul_done;
    logic w_bmul_i_val, w_bmul_o_rdy, w_bmul_capture, w_bmul_issue_ok, w_bmul_done;

    assign w_in_issue   = (r_state == ST_ISSUE);
    assign w_in_wait    = (r_state == ST_WAIT);
    assign w_all_issued = w_rmul_issue_ok & w_bmul_issue_ok;
    assign w_all_done   = w_rmul_done & w_bmul_done;
    assign w_clear      = w_in_wait & w_all_done;

    rsa_xcel_mont_MulRemTracker u_rmul_trk (
        .clk      (clk),
        .reset    (reset),
        .need     (r_need_rmul),
        .start    (w_in_issue),
        .wait_en  (w_in_wait),
        .clear    (w_clear),
        .i_rdy    (r_mulrem_i_rdy),
        .o_val    (r_mulrem_o_val),
        .i_val    (w_rmul_i_val),
        .o_rdy    (w_rmul_o_rdy),
        .capture  (w_rmul_capture),
        .issue_ok (w_rmul_issue_ok),
        .done     (w_rmul_done)
    );

    rsa_xcel_mont_MulRemTracker u_bmul_trk (
        .clk      (clk),
        .reset    (reset),
        .need     (r_need_bmul),
        .start    (w_in_issue),
        .wait_en  (w_in_wait),
        .clear    (w_clear),
        .i_rdy    (b_mulrem_i_rdy),
        .o_val    (b_mulrem_o_val),
        .i_val    (w_bmul_i_val),
        .o_rdy    (w_bmul_o_rdy),
        .capture  (w_bmul_capture),
        .issue_ok (w_bmul_issue_ok),
        .done     (w_bmul_done)
    );

    // State and per-iteration "needed" flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_need_rmul <= 1'b0;
            r_need_bmul <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (istream_val) begin
                        r_state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (e_reg_out == '0) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_need_rmul <= e_reg_out[0];
                        // The square on the last bit would never be used.
                        r_need_bmul <= (e_reg_out != p_nbits'(1));
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (w_all_issued) begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (w_all_done) begin
                        r_state <= ST_CHECK;
                    end
                end
                ST_DONE: begin
                    if (ostream_rdy) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decode from registered state/flags; the register enables also
    // follow the handshake that loads them. ostream_val depends on state only,
    // so ostream_rdy has no combinational path to it. Everything is forced
    // low while reset is held.
    always_comb begin
        istream_rdy    = 1'b0;
        ostream_val    = 1'b0;
        e_mux_sel      = SEL_LOAD;
        r_mux_sel      = SEL_LOAD;
        b_mux_sel      = SEL_LOAD;
        e_reg_en       = 1'b0;
        r_reg_en       = 1'b0;
        b_reg_en       = 1'b0;
        n_reg_en       = 1'b0;
        r_mulrem_i_val = w_rmul_i_val;
        r_mulrem_o_rdy = w_rmul_o_rdy;
        b_mulrem_i_val = w_bmul_i_val;
        b_mulrem_o_rdy = w_bmul_o_rdy;

        unique case (r_state)
            ST_IDLE: begin
                istream_rdy = 1'b1;
                if (istream_val) begin
                    e_reg_en = 1'b1;
                    r_reg_en = 1'b1;
                    b_reg_en = 1'b1;
                    n_reg_en = 1'b1;
                end
            end
            ST_WAIT: begin
                if (w_rmul_capture) begin
                    r_reg_en  = 1'b1;
                    r_mux_sel = SEL_UPD;
                end
                if (w_bmul_capture) begin
                    b_reg_en  = 1'b1;
                    b_mux_sel = SEL_UPD;
                end
                if (w_all_done) begin
                    e_reg_en  = 1'b1;
                    e_mux_sel = SEL_UPD;
                end
            end
            ST_DONE: begin
                ostream_val = 1'b1;
            end
            default: begin
            end
        endcase

        if (reset) begin
            istream_rdy    = 1'b0;
            ostream_val    = 1'b0;
            e_mux_sel      = SEL_LOAD;
            r_mux_sel      = SEL_LOAD;
            b_mux_sel      = SEL_LOAD;
            e_reg_en       = 1'b0;
            r_reg_en       = 1'b0;
            b_reg_en       = 1'b0;
            n_reg_en       = 1'b0;
            r_mulrem_i_val = 1'b0;
            r_mulrem_o_rdy = 1'b0;
            b_mulrem_i_val = 1'b0;
            b_mulrem_o_rdy = 1'b0;
        end
    end

endmodule
`default_nettype wire
